num_toupper: RTL and testbench
==============================

Name: num_toupper

Overview:
- Byte-wide ASCII lowercase-to-uppercase converter. Stands in the design for the `num` DUT.
- Each accepted input byte in 0x61..0x7A ('a'..'z') is emitted with 0x20 subtracted. Every other byte, including 0x80..0xFF, passes through unchanged.
- Registered single-stage pipeline with valid flags. Sits between a byte source and a byte sink.

Parameters:
- CNT_W, 16, width of the saturating count of converted characters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input byte is presented this cycle.
- i7..i0  input  1 each  input byte bits, i7 = MSB.
- out_valid  output  1  o7..o0 hold a result this cycle.
- o7..o0  output  1 each  output byte bits, o7 = MSB.
- changed  output  1  the current output byte was case-converted.
- conv_count  output  CNT_W  number of bytes converted since reset.

Behaviour:
- Reset (rst_n low, asynchronous, any time): o7..o0 = 0x00, out_valid = 0, changed = 0, conv_count = 0. Outputs hold these values until the first clk edge after rst_n deasserts.
- Combinational core: lower = (in >= 0x61) && (in <= 0x7A); res = lower ? in - 0x20 : in. Only bit 5 changes, so in ^ 0x20 is equivalent.
- Latency: exactly 1 cycle. On a rising edge with in_valid = 1:
  - o <= res
  - changed <= lower
  - out_valid <= 1
  - if lower and conv_count != max, conv_count <= conv_count + 1
- On a rising edge with in_valid = 0: out_valid <= 0. o and changed hold their last values. conv_count holds.
- No backpressure; the sink must accept every cycle. Back-to-back bytes are sustained at one per cycle.
- Boundaries:
  - 0x60 ('`') and 0x7B ('{') are unchanged.
  - 0x61 -> 0x41; 0x7A -> 0x5A.
  - Uppercase 0x41..0x5A is unchanged (idempotent).
  - 0x7F is unchanged.
  - The high half 0x80..0xFF is never converted; there is no Latin-1 folding.
- conv_count saturates at 2^CNT_W-1 and never wraps.
- A reset asserted mid-stream drops the in-flight byte and clears all outputs immediately.
- X on i* while in_valid = 0 must not propagate into out_valid or conv_count.

Decomposition:
- Shared package `ascii_pkg` holds:
  - ASCII_LOWER_A = 8'h61
  - ASCII_LOWER_Z = 8'h7A
  - ASCII_CASE_DELTA = 8'h20
- One combinational sub-module, `ascii_upper_conv`:
  - input 8-bit byte; outputs 8-bit result and the lower flag.
  - Instantiated once.
- The top level holds the output register, the valid register and the saturating counter.

Test Plan:
- Reset: hold rst_n low with random i*/in_valid -> o = 0x00, out_valid = 0, changed = 0, conv_count = 0. Release rst_n; the first valid byte appears one cycle later.
- Letter conversion, one byte per cycle:
  - 0x61 -> 0x41, changed = 1
  - 0x7A -> 0x5A, changed = 1
  - 0x6D -> 0x4D, changed = 1
  - conv_count ends at 3
- Pass-through, changed = 0 for all:
  - 0x28, 0x48, 0x41, 0x47, 0x30, 0x3A, 0x14 -> identical
  - 0x7C, 0x7B, 0x7F, 0x60 -> identical
- High-half pass-through: 0xB7, 0x83, 0xEB, 0x92, 0xCF, 0x84 -> identical, changed = 0, conv_count unchanged.
- Valid gaps: alternate in_valid 1/0 with 0x61 then 0x00 -> out_valid toggles with 1-cycle lag, o holds 0x41 during gaps, conv_count increments once per valid 'a'.
- Saturation and reset mid-stream: force conv_count near max with CNT_W = 4, feed 20 lowercase bytes -> count sticks at 15. Pulse rst_n low mid-stream -> outputs clear asynchronously before the next edge.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared ASCII constants for the case-conversion datapath.
package ascii_pkg;
    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;
endpackage

// File: rtl/num_toupper_if.sv
// Byte stream bundle between a source (master) and the converter (slave).
interface num_toupper_if #(parameter int unsigned CNT_W = 16);
    logic             in_valid;
    logic             i7, i6, i5, i4, i3, i2, i1, i0;
    logic             out_valid;
    logic             o7, o6, o5, o4, o3, o2, o1, o0;
    logic             changed;
    logic [CNT_W-1:0] conv_count;

    modport master (
        output in_valid, i7, i6, i5, i4, i3, i2, i1, i0,
        input  out_valid, o7, o6, o5, o4, o3, o2, o1, o0, changed, conv_count
    );

    modport slave (
        input  in_valid, i7, i6, i5, i4, i3, i2, i1, i0,
        output out_valid, o7, o6, o5, o4, o3, o2, o1, o0, changed, conv_count
    );
endinterface

// File: rtl/ascii_upper_conv.sv
// Combinational lowercase-to-uppercase mapping for one ASCII byte.
module ascii_upper_conv
    import ascii_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] res,
    output logic       lower
);
    always_comb begin
        lower = (in_byte >= ASCII_LOWER_A) && (in_byte <= ASCII_LOWER_Z);
        res   = lower ? (in_byte - ASCII_CASE_DELTA) : in_byte;
    end
endmodule

// File: rtl/num_toupper.sv
// Single-stage registered ASCII upper-caser with a saturating conversion count.
module num_toupper #(
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    num_toupper_if.slave bus
);
    logic [7:0]       in_byte;
    logic [7:0]       res;
    logic             lower;
    logic [7:0]       o_q;
    logic             valid_q;
    logic             changed_q;
    logic [CNT_W-1:0] count_q;

    assign in_byte = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};

    ascii_upper_conv u_conv (
        .in_byte (in_byte),
        .res     (res),
        .lower   (lower)
    );

    // Data and flags only load on in_valid so X on idle inputs cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                o_q       <= res;
                changed_q <= lower;
                if (lower && (count_q != '1))
                    count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.changed    = changed_q;
    assign bus.conv_count = count_q;
    assign {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0} = o_q;
endmodule

// File: tb/tb_num_toupper.sv
// Directed self-checking bench for num_toupper (default and 4-bit counter builds).
module tb_num_toupper;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;
    int   exp4;

    num_toupper_if #(.CNT_W(16)) bus ();
    num_toupper_if #(.CNT_W(4))  bus4 ();

    num_toupper #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    num_toupper #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [7:0] b);
        bus.in_valid = v;
        {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = b;
    endtask

    task automatic set_in4(input logic v, input logic [7:0] b);
        bus4.in_valid = v;
        {bus4.i7, bus4.i6, bus4.i5, bus4.i4, bus4.i3, bus4.i2, bus4.i1, bus4.i0} = b;
    endtask

    function automatic logic [7:0] out_byte();
        return {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
    endfunction

    function automatic logic [7:0] out_byte4();
        return {bus4.o7, bus4.o6, bus4.o5, bus4.o4, bus4.o3, bus4.o2, bus4.o1, bus4.o0};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp4    = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in4(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1'($urandom_range(0, 1)), 8'($urandom));
        end
        #1;
        n_checks++;
        if (out_byte() !== 8'h00 || bus.out_valid !== 1'b0 || bus.changed !== 1'b0 ||
            bus.conv_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: o=%h ov=%b ch=%b cnt=%0d, required o=00 ov=0 ch=0 cnt=0",
                     out_byte(), bus.out_valid, bus.changed, bus.conv_count);
        end
        n_checks++;
        if (out_byte4() !== 8'h00 || bus4.out_valid !== 1'b0 || bus4.conv_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state4: o=%h ov=%b cnt=%0d, required 00/0/0",
                     out_byte4(), bus4.out_valid, bus4.conv_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 8'h61);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_bypass: ov=%b, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || out_byte() !== 8'h41 || bus.changed !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_byte: ov=%b o=%h ch=%b, required 1/41/1",
                     bus.out_valid, out_byte(), bus.changed);
        end
    endtask

    task automatic test_letters();
        logic [7:0] vin [3]  = '{8'h61, 8'h7A, 8'h6D};
        logic [7:0] vexp [3] = '{8'h41, 8'h5A, 8'h4D};
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1'b1, vin[i]);
            @(posedge clk); #1;
            n_checks++;
            if (out_byte() !== vexp[i] || bus.changed !== 1'b1 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL letter_%h: o=%h ch=%b ov=%b, required %h/1/1",
                         vin[i], out_byte(), bus.changed, bus.out_valid, vexp[i]);
            end
        end
        n_checks++;
        if (bus.conv_count !== 16'd3) begin
            n_fail++;
            $display("FAIL letter_count: cnt=%0d, required 3", bus.conv_count);
        end
        exp_cnt = 3;
    endtask

    task automatic test_passthrough();
        logic [7:0] vin [17] = '{8'h28, 8'h48, 8'h41, 8'h47, 8'h30, 8'h3A, 8'h14,
                                 8'h7C, 8'h7B, 8'h7F, 8'h60,
                                 8'hB7, 8'h83, 8'hEB, 8'h92, 8'hCF, 8'h84};
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            set_in(1'b1, vin[i]);
            @(posedge clk); #1;
            n_checks++;
            if (out_byte() !== vin[i] || bus.changed !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.conv_count !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL pass_%h: o=%h ch=%b ov=%b cnt=%0d, required %h/0/1/%0d",
                         vin[i], out_byte(), bus.changed, bus.out_valid, bus.conv_count,
                         vin[i], exp_cnt);
            end
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1'b1, 8'h61);
            exp_cnt++;
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || out_byte() !== 8'h41 || bus.changed !== 1'b1 ||
                bus.conv_count !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL gap_valid_%0d: ov=%b o=%h ch=%b cnt=%0d, required 1/41/1/%0d",
                         i, bus.out_valid, out_byte(), bus.changed, bus.conv_count, exp_cnt);
            end
            @(negedge clk);
            // Odd gaps drive X on the idle byte; nothing may pick it up.
            if (i % 2 == 0) set_in(1'b0, 8'h00);
            else            set_in(1'b0, 8'hxx);
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b0 || out_byte() !== 8'h41 || bus.changed !== 1'b1 ||
                bus.conv_count !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL gap_idle_%0d: ov=%b o=%h ch=%b cnt=%0d, required 0/41/1/%0d",
                         i, bus.out_valid, out_byte(), bus.changed, bus.conv_count, exp_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_in4(1'b1, 8'h62);
            if (exp4 < 15) exp4++;
            @(posedge clk); #1;
            n_checks++;
            if (bus4.conv_count !== 4'(exp4) || out_byte4() !== 8'h42) begin
                n_fail++;
                $display("FAIL sat_%0d: cnt=%0d o=%h, required %0d/42",
                         i, bus4.conv_count, out_byte4(), exp4);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        set_in(1'b1, 8'h7A);
        set_in4(1'b1, 8'h63);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_byte4() !== 8'h00 || bus4.out_valid !== 1'b0 || bus4.changed !== 1'b0 ||
            bus4.conv_count !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_async4: o=%h ov=%b ch=%b cnt=%0d, required 00/0/0/0",
                     out_byte4(), bus4.out_valid, bus4.changed, bus4.conv_count);
        end
        n_checks++;
        if (out_byte() !== 8'h00 || bus.out_valid !== 1'b0 || bus.conv_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_async: o=%h ov=%b cnt=%0d, required 00/0/0",
                     out_byte(), bus.out_valid, bus.conv_count);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_byte() !== 8'h00 || bus.out_valid !== 1'b0 || bus.changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_drop: o=%h ov=%b ch=%b, required 00/0/0",
                     out_byte(), bus.out_valid, bus.changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 8'h00);
        set_in4(1'b0, 8'h00);
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.conv_count !== 16'd0 || bus4.conv_count !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_release: ov=%b cnt=%0d cnt4=%0d, required 0/0/0",
                     bus.out_valid, bus.conv_count, bus4.conv_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        exp4     = 0;
        test_reset();
        test_letters();
        test_passthrough();
        test_gaps();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
